dp_ram: RTL and testbench

Parametrised simple dual-port synchronous RAM: one write port, one read port, same clock. Adds byte-enable writes, a selectable read-during-write policy, an optional output register and a hardware initialisation sequencer that fills the array after reset. It is the general-purpose on-chip buffer for the display and memory subsystems and replaces fixed 8-bit × 64 single-port storage.

---
 rtl/dp_ram_pkg.sv | 32 +++
 rtl/dp_ram_init_seq.sv | 72 +++++++
 rtl/dp_ram.sv | 119 +++++++++++
 tb/tb_dp_ram.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram buffer.
package dp_ram_pkg;

    typedef enum logic {
        INIT,
        READY
    } state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Widest word the byte-merge helper handles; callers extend/truncate.
    localparam int unsigned MERGE_DW = 256;
    localparam int unsigned MERGE_BW = MERGE_DW / 8;

    // Replace the bytes of old_word selected by be with those of new_word.
    function automatic logic [MERGE_DW-1:0] byte_merge(
        input logic [MERGE_DW-1:0] old_word,
        input logic [MERGE_DW-1:0] new_word,
        input logic [MERGE_BW-1:0] be
    );
        logic [MERGE_DW-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MERGE_BW; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dp_ram_init_seq.sv
// Post-reset fill sequencer; owns the write port until every word holds INIT_VAL.
module dp_ram_init_seq
    import dp_ram_pkg::*;
#(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 6,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [DW-1:0]   i_wr_data,
    input  logic [DW/8-1:0] i_wr_be,
    input  logic            i_rd_en,
    output logic            o_init_busy,
    output logic            o_mem_we,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wdata,
    output logic [DW/8-1:0] o_mem_be,
    output logic            o_rd_accept
);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;

    // State and fill-address registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and array write-port mux: fill during INIT, user port in READY.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_mem_we    = 1'b0;
        o_mem_addr  = i_wr_addr;
        o_mem_wdata = i_wr_data;
        o_mem_be    = i_wr_be;
        o_rd_accept = 1'b0;
        case (r_state)
            INIT: begin
                o_mem_we    = 1'b1;
                o_mem_addr  = r_cnt;
                o_mem_wdata = INIT_VAL;
                o_mem_be    = '1;
                w_cnt_nxt   = r_cnt + AW'(1);
                if (r_cnt == '1) begin
                    w_state_nxt = READY;
                end
            end
            READY: begin
                o_mem_we    = i_wr_en;
                o_rd_accept = i_rd_en;
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign o_init_busy = (r_state == INIT);

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM with byte enables, RDW policy, optional output register
// and a post-reset fill sequencer.
module dp_ram
    import dp_ram_pkg::*;
#(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 6,
    parameter int unsigned   RDW_MODE = 0,
    parameter int unsigned   OUT_REG  = 0,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            init_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_be,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    output logic            rd_valid
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned BW    = DW / 8;

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [DW-1:0] w_wdata;
    logic [BW-1:0] w_wbe;
    logic          w_rd_acc;
    logic [DW-1:0] w_rd_word;
    logic          r_rd_v1;
    logic [DW-1:0] r_rd_d1;

    dp_ram_init_seq #(
        .DW       (DW),
        .AW       (AW),
        .INIT_VAL (INIT_VAL)
    ) u_init_seq (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_wr_be     (wr_be),
        .i_rd_en     (rd_en),
        .o_init_busy (init_busy),
        .o_mem_we    (w_we),
        .o_mem_addr  (w_waddr),
        .o_mem_wdata (w_wdata),
        .o_mem_be    (w_wbe),
        .o_rd_accept (w_rd_acc)
    );

    // Byte-masked array write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int unsigned i = 0; i < BW; i++) begin
                if (w_wbe[i]) begin
                    r_mem[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read word selection; in new-data mode a same-address write is merged in.
    always_comb begin
        w_rd_word = r_mem[rd_addr];
        if ((RDW_MODE == RDW_NEW) && w_we && (w_waddr == rd_addr)) begin
            w_rd_word = DW'(byte_merge(MERGE_DW'(r_mem[rd_addr]),
                                       MERGE_DW'(w_wdata),
                                       MERGE_BW'(w_wbe)));
        end
    end

    // First read stage; data only moves on an accepted read so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_v1 <= 1'b0;
            r_rd_d1 <= '0;
        end else begin
            r_rd_v1 <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_d1 <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic          r_rd_v2;
            logic [DW-1:0] r_rd_d2;

            // Second read stage, loaded only when stage one carries new data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rd_v2 <= 1'b0;
                    r_rd_d2 <= '0;
                end else begin
                    r_rd_v2 <= r_rd_v1;
                    if (r_rd_v1) begin
                        r_rd_d2 <= r_rd_d1;
                    end
                end
            end

            assign rd_valid = r_rd_v2;
            assign rd_data  = r_rd_d2;
        end else begin : g_no_out_reg
            assign rd_valid = r_rd_v1;
            assign rd_data  = r_rd_d1;
        end
    endgenerate

endmodule

// File: tb/tb_dp_ram.sv
// Directed bench for dp_ram: two instances share stimulus, one old-data /
// single-register, one new-data / output-registered.
module tb_dp_ram;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        rd_en;
    logic [3:0]  rd_addr;

    logic        busy_a, busy_b;
    logic [15:0] rd_a, rd_b;
    logic        rv_a, rv_b;

    int checks = 0;
    int errors = 0;

    dp_ram #(
        .DW       (16),
        .AW       (4),
        .RDW_MODE (0),
        .OUT_REG  (0),
        .INIT_VAL (16'hA5A5)
    ) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (busy_a),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_a),
        .rd_valid  (rv_a)
    );

    dp_ram #(
        .DW       (16),
        .AW       (4),
        .RDW_MODE (1),
        .OUT_REG  (1),
        .INIT_VAL (16'hA5A5)
    ) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (busy_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_b),
        .rd_valid  (rv_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int i);
        return 16'h1000 + 16'(i) * 16'h0111;
    endfunction

    task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        step();
        wr_en   = 1'b0;
    endtask

    // Single read: A answers one edge after rd_en, B two edges after.
    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [15:0] exp_a, input logic [15:0] exp_b);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
        check({tag, "_a_valid"}, 32'(rv_a), 32'd1);
        check({tag, "_a_data"},  32'(rd_a), 32'(exp_a));
        check({tag, "_b_early"}, 32'(rv_b), 32'd0);
        step();
        check({tag, "_a_pulse"}, 32'(rv_a), 32'd0);
        check({tag, "_a_hold"},  32'(rd_a), 32'(exp_a));
        check({tag, "_b_valid"}, 32'(rv_b), 32'd1);
        check({tag, "_b_data"},  32'(rd_b), 32'(exp_b));
    endtask

    // 16 back-to-back reads of addresses 0..15.
    task automatic stream(input bit use_pat);
        logic [15:0] exp_d;
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                rd_en   = 1'b1;
                rd_addr = 4'(i);
            end else begin
                rd_en   = 1'b0;
            end
            step();
            check("stream_a_valid", 32'(rv_a), (i < 16) ? 32'd1 : 32'd0);
            if (i < 16) begin
                exp_d = use_pat ? pat(i) : 16'hA5A5;
                check("stream_a_data", 32'(rd_a), 32'(exp_d));
            end
            check("stream_b_valid", 32'(rv_b), (i >= 1 && i <= 16) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 16) begin
                exp_d = use_pat ? pat(i - 1) : 16'hA5A5;
                check("stream_b_data", 32'(rd_b), 32'(exp_d));
            end
        end
        rd_en = 1'b0;
    endtask

    // Count edges until A's init_busy falls; bounded.
    task automatic count_init(input string tag, input bit poke);
        int n;
        bit saw_valid;
        n = 0;
        saw_valid = 1'b0;
        if (poke) begin
            wr_en   = 1'b1;
            wr_addr = 4'd2;
            wr_data = 16'hFFFF;
            wr_be   = 2'b11;
            rd_en   = 1'b1;
            rd_addr = 4'd2;
        end
        while (busy_a === 1'b1 && n < 40) begin
            step();
            n++;
            if (rv_a !== 1'b0 || rv_b !== 1'b0) saw_valid = 1'b1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        check({tag, "_busy_cycles"}, 32'(n), 32'd16);
        check({tag, "_busy_b_low"},  32'(busy_b), 32'd0);
        check({tag, "_no_valid"},    32'(saw_valid), 32'd0);
        step();
        check({tag, "_a_idle"}, 32'(rv_a), 32'd0);
        check({tag, "_b_idle"}, 32'(rv_b), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_be   = '0;
        rd_en   = 1'b0;
        rd_addr = '0;

        // Reset state
        step();
        step();
        check("rst_busy_a",  32'(busy_a), 32'd1);
        check("rst_busy_b",  32'(busy_b), 32'd1);
        check("rst_valid_a", 32'(rv_a), 32'd0);
        check("rst_valid_b", 32'(rv_b), 32'd0);
        check("rst_data_a",  32'(rd_a), 32'd0);
        check("rst_data_b",  32'(rd_b), 32'd0);

        // Init fill with requests driven during init
        rst_n = 1'b1;
        count_init("init", 1'b1);

        // Every word holds INIT_VAL, address 2 untouched by init-time write
        stream(1'b0);

        // Distinct pattern, then in-order streaming
        for (int i = 0; i < 16; i++) wr(4'(i), pat(i), 2'b11);
        stream(1'b1);

        // Byte enables
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        rd_chk("be_merge", 4'd3, 16'h12CD, 16'h12CD);
        wr(4'd3, 16'hFFFF, 2'b00);
        rd_chk("be_none", 4'd3, 16'h12CD, 16'h12CD);

        // Read-during-write, same address
        wr(4'd5, 16'h1111, 2'b11);
        wr_en   = 1'b1;
        wr_addr = 4'd5;
        wr_data = 16'h2222;
        wr_be   = 2'b10;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rdw_a_valid", 32'(rv_a), 32'd1);
        check("rdw_a_old",   32'(rd_a), 32'h1111);
        step();
        check("rdw_b_valid", 32'(rv_b), 32'd1);
        check("rdw_b_new",   32'(rd_b), 32'h2211);
        rd_chk("rdw_after", 4'd5, 16'h2211, 16'h2211);

        // Same-cycle write and read to different addresses
        wr_en   = 1'b1;
        wr_addr = 4'd6;
        wr_data = 16'h6666;
        wr_be   = 2'b11;
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("indep_a", 32'(rd_a), 32'h2211);
        step();
        check("indep_b", 32'(rd_b), 32'h2211);
        rd_chk("indep_wr", 4'd6, 16'h6666, 16'h6666);

        // Asynchronous reset clears read outputs immediately
        rst_n = 1'b0;
        #1;
        check("async_data_a",  32'(rd_a), 32'd0);
        check("async_data_b",  32'(rd_b), 32'd0);
        check("async_busy_a",  32'(busy_a), 32'd1);
        step();
        rst_n = 1'b1;

        // Reset at init count 7, then a full restart
        for (int i = 0; i < 7; i++) step();
        check("mid_busy", 32'(busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_valid_a", 32'(rv_a), 32'd0);
        check("mid_data_a",  32'(rd_a), 32'd0);
        check("mid_data_b",  32'(rd_b), 32'd0);
        step();
        rst_n = 1'b1;
        count_init("reinit", 1'b0);
        rd_chk("refill_6",  4'd6,  16'hA5A5, 16'hA5A5);
        rd_chk("refill_15", 4'd15, 16'hA5A5, 16'hA5A5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
